// File: rtl/bp_initiator.sv
// Bus-protocol initiator: queues commands, issues them one at a time on bp_*, holds each response until it is consumed.
// Latency: push at edge N -> bus request after N+1 -> response after N+2 when there is no stall.
// Backpressure: cmd_ready drops when the queue is full; bp_request_stall holds the bus request; rsp_ready=0 holds the response.
// Optional: BP_TIMEOUT_EN abandons a transfer after TIMEOUT_CYCLES consecutive stall cycles.
module bp_initiator #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strobe,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic [31:0] bp_addr,
    output logic [31:0] bp_wdata,
    output logic [3:0]  bp_strobe,
    output logic        bp_wen,
    output logic        bp_ren,
    input  logic [31:0] bp_rdata,
    input  logic        bp_error,
    input  logic        bp_request_stall
);

    localparam int PW = $clog2(CMD_DEPTH);

    if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strobe;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Command queue: pointers carry one extra bit to tell full from empty.
    cmd_t          mem_q [CMD_DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          q_full, q_empty;
    logic          push, pop;
    cmd_t          cmd_in, head;

    assign q_empty   = (wr_ptr_q == rd_ptr_q);
    assign q_full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign cmd_ready = ~q_full;
    assign push      = cmd_valid & ~q_full;
    assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strobe: cmd_strobe};
    assign head      = mem_q[rd_ptr_q[PW-1:0]];
    assign wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Transfer FSM and registered bus / response outputs.
    state_t        state_q, state_d;
    logic [31:0]   bp_addr_q, bp_addr_d;
    logic [31:0]   bp_wdata_q, bp_wdata_d;
    logic [3:0]    bp_strobe_q, bp_strobe_d;
    logic          bp_wen_q, bp_wen_d;
    logic          bp_ren_q, bp_ren_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_error_q, rsp_error_d;
`ifdef BP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        bp_addr_d   = bp_addr_q;
        bp_wdata_d  = bp_wdata_q;
        bp_strobe_d = bp_strobe_q;
        bp_wen_d    = bp_wen_q;
        bp_ren_d    = bp_ren_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        pop         = 1'b0;
`ifdef BP_TIMEOUT_EN
        stall_cnt_d   = stall_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    pop         = 1'b1;
                    bp_addr_d   = head.addr;
                    bp_wdata_d  = head.wdata;
                    bp_strobe_d = head.strobe;
                    bp_wen_d    = head.write;
                    bp_ren_d    = ~head.write;
                    state_d     = REQ;
`ifdef BP_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            REQ: begin
                if (!bp_request_stall) begin
                    bp_wen_d    = 1'b0;
                    bp_ren_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bp_ren_q ? bp_rdata : 32'd0;
                    rsp_error_d = bp_error;
                    state_d     = RESP;
`ifdef BP_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (stall_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // This edge is the TIMEOUT_CYCLES-th consecutive stall: give up.
                    bp_wen_d      = 1'b0;
                    bp_ren_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'd0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_error_d = 1'b0;
                    state_d     = IDLE;
`ifdef BP_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                bp_wen_d = 1'b0;
                bp_ren_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            bp_addr_q   <= '0;
            bp_wdata_q  <= '0;
            bp_strobe_q <= '0;
            bp_wen_q    <= 1'b0;
            bp_ren_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bp_addr_q   <= bp_addr_d;
            bp_wdata_q  <= bp_wdata_d;
            bp_strobe_q <= bp_strobe_d;
            bp_wen_q    <= bp_wen_d;
            bp_ren_q    <= bp_ren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef BP_TIMEOUT_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stall_cnt_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign bp_addr   = bp_addr_q;
    assign bp_wdata  = bp_wdata_q;
    assign bp_strobe = bp_strobe_q;
    assign bp_wen    = bp_wen_q;
    assign bp_ren    = bp_ren_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_bp_initiator.sv
// Directed bench for bp_initiator: transaction-level model checked every cycle, plus literal expectations per scenario.
// Builds with or without BP_TIMEOUT_EN.
module tb_bp_initiator;

    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strobe = '0;
    logic        cmd_ready, rsp_valid, rsp_error, rsp_timeout;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata, bp_addr, bp_wdata;
    logic [3:0]  bp_strobe;
    logic        bp_wen, bp_ren;
    logic [31:0] bp_rdata = '0;
    logic        bp_error = 1'b0, bp_request_stall = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_initiator #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nReset(nReset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .bp_addr(bp_addr), .bp_wdata(bp_wdata), .bp_strobe(bp_strobe),
        .bp_wen(bp_wen), .bp_ren(bp_ren), .bp_rdata(bp_rdata),
        .bp_error(bp_error), .bp_request_stall(bp_request_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: commands wait in 'pending'; the bus carries at most one; a response blocks new issues.
    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } tcmd_t;

    tcmd_t       pending[$];
    tcmd_t       cur;
    bit          busy, held;
    int          scnt;
    logic [31:0] exp_rdata;
    bit          exp_err, exp_to;

    always @(posedge clk or negedge nReset) begin : model
        bit    push_now;
        tcmd_t c;
        if (!nReset) begin
            pending.delete();
            busy = 0; held = 0; scnt = 0;
            exp_rdata = '0; exp_err = 0; exp_to = 0;
        end else begin
            push_now = cmd_valid && (pending.size() < DEPTH);
            c = '{w: cmd_write, a: cmd_addr, d: cmd_wdata, s: cmd_strobe};
            if (!busy && !held) begin
                if (pending.size() > 0) begin
                    cur = pending.pop_front();
                    busy = 1; scnt = 0;
                end
            end else if (busy) begin
                if (!bp_request_stall) begin
                    busy = 0; held = 1;
                    exp_rdata = cur.w ? 32'd0 : bp_rdata;
                    exp_err = bp_error; exp_to = 0;
                end else begin
`ifdef BP_TIMEOUT_EN
                    scnt++;
                    if (scnt == TO) begin
                        busy = 0; held = 1;
                        exp_rdata = 32'd0; exp_err = 1; exp_to = 1;
                    end
`endif
                end
            end else if (rsp_ready) begin
                held = 0;
            end
            if (push_now) pending.push_back(c);
        end
    end

    always @(negedge clk) begin : compare
        chk("wen_ren_exclusive", {31'd0, bp_wen & bp_ren}, 32'd0);
        if (!nReset) begin
            chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_bp_req", {30'd0, bp_wen, bp_ren}, 32'd0);
            chk("rst_bp_addr", bp_addr, 32'd0);
            chk("rst_bp_wdata", bp_wdata, 32'd0);
            chk("rst_bp_strobe", {28'd0, bp_strobe}, 32'd0);
            chk("rst_rsp_bits", {30'd0, rsp_error, rsp_timeout}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        end else begin
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, pending.size() < DEPTH});
            chk("bp_wen", {31'd0, bp_wen}, {31'd0, busy && cur.w});
            chk("bp_ren", {31'd0, bp_ren}, {31'd0, busy && !cur.w});
            if (busy) begin
                chk("bp_addr", bp_addr, cur.a);
                chk("bp_wdata", bp_wdata, cur.d);
                chk("bp_strobe", {28'd0, bp_strobe}, {28'd0, cur.s});
            end
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, held});
            if (held) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
                chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
            end
        end
    end

    // Log of bus transfer start addresses as seen on the DUT pins.
    logic [31:0] dut_log[$];
    bit          prev_req = 0;
    always @(negedge clk) begin
        if ((bp_wen || bp_ren) && !prev_req) dut_log.push_back(bp_addr);
        prev_req = bp_wen || bp_ren;
    end

    task automatic offer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output bit acc);
        @(negedge clk);
        #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strobe = s;
        @(posedge clk);
        acc = cmd_ready;
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        bit          acc;
        int          cnt, acc_cnt, base, act_cnt;
        bit          saw_rsp, last_acc;
        logic [31:0] cap_a, cap_d, cap_r;
        logic [3:0]  cap_s;
        bit          cap_e, cap_t;

        // Reset state
        repeat (3) @(negedge clk);
        chk("lit_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("lit_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        #1 nReset = 1'b1;

        // Single write, no stall
        rsp_ready = 1; bp_request_stall = 0;
        offer(1, 32'd24, 32'hCCCC_FFFF, 4'hF, acc);
        cnt = 0; saw_rsp = 0; cap_a = '0; cap_d = '0; cap_s = '0; cap_r = 32'hDEAD; cap_e = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bp_wen) begin cnt++; cap_a = bp_addr; cap_d = bp_wdata; cap_s = bp_strobe; end
            if (rsp_valid) begin saw_rsp = 1; cap_r = rsp_rdata; cap_e = rsp_error; end
        end
        chk("lit_wr_accept", {31'd0, acc}, 32'd1);
        chk("lit_wr_wen_cycles", cnt, 32'd1);
        chk("lit_wr_addr", cap_a, 32'd24);
        chk("lit_wr_wdata", cap_d, 32'hCCCC_FFFF);
        chk("lit_wr_strobe", {28'd0, cap_s}, 32'hF);
        chk("lit_wr_rsp_seen", {31'd0, saw_rsp}, 32'd1);
        chk("lit_wr_rsp_rdata", cap_r, 32'd0);
        chk("lit_wr_rsp_error", {31'd0, cap_e}, 32'd0);

        // Read with three stall cycles
        bp_request_stall = 1; bp_rdata = 32'h0000_0055;
        offer(0, 32'd20, 32'd0, 4'hF, acc);
        cnt = 0; saw_rsp = 0; cap_r = '0; act_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bp_ren) begin cnt++; if (bp_addr != 32'd20) act_cnt++; end
            if (rsp_valid) begin saw_rsp = 1; cap_r = rsp_rdata; end
            if (bp_ren && cnt == 4) #1 bp_request_stall = 0;
        end
        chk("lit_rd_ren_cycles", cnt, 32'd4);
        chk("lit_rd_addr_unstable", act_cnt, 32'd0);
        chk("lit_rd_rsp_seen", {31'd0, saw_rsp}, 32'd1);
        chk("lit_rd_rsp_rdata", cap_r, 32'h55);

        // Fill the queue behind a stalled transfer, then drain and check order
        bp_request_stall = 1; base = dut_log.size(); acc_cnt = 0; last_acc = 1;
        for (int i = 0; i < 6; i++) begin
            offer(1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 4'h3, acc);
            if (acc) acc_cnt++;
            last_acc = acc;
        end
        chk("lit_fill_accepted", acc_cnt, 32'd5);
        chk("lit_fill_sixth_ready", {31'd0, last_acc}, 32'd0);
        chk("lit_fill_ready_now", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk); #1 bp_request_stall = 0;
        repeat (40) @(negedge clk);
        chk("lit_fill_issue_count", dut_log.size() - base, 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < dut_log.size())
                chk("lit_fill_issue_order", dut_log[base + i], 32'h100 + 32'(4 * i));
        end

        // Write error, response held back: next command must wait
        rsp_ready = 0; bp_error = 1;
        offer(1, 32'h40, 32'h1, 4'h1, acc);
        offer(1, 32'h44, 32'h2, 4'h2, acc);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bp_wen || bp_ren) cnt++;
        end
        chk("lit_err_bus_cycles", cnt, 32'd1);
        chk("lit_err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lit_err_rsp_error", {31'd0, rsp_error}, 32'd1);
        chk("lit_err_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        #1 bp_error = 0; rsp_ready = 1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bp_wen) begin cnt++; cap_a = bp_addr; end
        end
        chk("lit_err_next_issued", cnt, 32'd1);
        chk("lit_err_next_addr", cap_a, 32'h44);

        // Permanently stalled read
        bp_request_stall = 1; bp_rdata = 32'h1234_5678;
        offer(0, 32'h80, 32'd0, 4'hF, acc);
`ifdef BP_TIMEOUT_EN
        cnt = 0; saw_rsp = 0; cap_e = 0; cap_t = 0; cap_r = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bp_ren) cnt++;
            if (rsp_valid) begin saw_rsp = 1; cap_e = rsp_error; cap_t = rsp_timeout; cap_r = rsp_rdata; end
        end
        chk("lit_to_ren_cycles", cnt, TO);
        chk("lit_to_rsp_seen", {31'd0, saw_rsp}, 32'd1);
        chk("lit_to_rsp_error", {31'd0, cap_e}, 32'd1);
        chk("lit_to_rsp_timeout", {31'd0, cap_t}, 32'd1);
        chk("lit_to_rsp_rdata", cap_r, 32'd0);
`else
        repeat (1000) @(negedge clk);
        chk("lit_nto_ren_held", {31'd0, bp_ren}, 32'd1);
        chk("lit_nto_rsp_valid", {31'd0, rsp_valid}, 32'd0);
`endif

        // Reset while a transfer is active with commands queued
        offer(1, 32'h200, 32'h5, 4'hF, acc);
        offer(1, 32'h204, 32'h6, 4'hF, acc);
        offer(1, 32'h208, 32'h7, 4'hF, acc);
        @(negedge clk);
        chk("lit_rst_bus_active", {31'd0, bp_wen | bp_ren}, 32'd1);
        #1 nReset = 0;
        #1;
        chk("lit_rst_bus_drop", {30'd0, bp_wen, bp_ren}, 32'd0);
        chk("lit_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lit_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        #1 nReset = 1; bp_request_stall = 0;
        cnt = 0; act_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bp_wen || bp_ren) cnt++;
            if (rsp_valid || !cmd_ready) act_cnt++;
        end
        chk("lit_rst_no_reissue", cnt, 32'd0);
        chk("lit_rst_quiet_rsp", act_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
